psram_channel_responder: RTL and testbench

//  Slave-side model of one PSRAM HS controller user channel (cmd/cmd_en/addr/wr_data/data_mask in, rd_data/rd_data_valid/init_calib out).

---
 rtl/psram_channel_responder.sv | 185 ++++++++++++++++++
 tb/tb_psram_channel_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_channel_responder.sv
// psram_channel_responder: BRAM-backed stand-in for one PSRAM HS controller user channel.
// Reproduces the channel's calibration delay, burst write timing and fixed read latency.
module psram_channel_responder #(
   parameter int unsigned MEM_AW       = 12,
   parameter int unsigned ADDR_WIDTH   = 21,
   parameter int unsigned BURST_WORDS  = 4,
   parameter int unsigned RD_LATENCY   = 6,
   parameter int unsigned CALIB_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  init_calib,
   input  logic                  cmd,
   input  logic                  cmd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wr_data,
   input  logic [3:0]            data_mask,
   output logic [31:0]           rd_data,
   output logic                  rd_data_valid,
   output logic                  cmd_overrun
);

   localparam int unsigned DEPTH = 1 << MEM_AW;
   localparam int unsigned CAL_W = $clog2(CALIB_CYCLES + 1);
   localparam int unsigned CNT_W = 5;

   typedef enum logic [2:0] {
      CALIB   = 3'd0,
      IDLE    = 3'd1,
      WRITE   = 3'd2,
      RD_WAIT = 3'd3,
      RD_DATA = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [CAL_W-1:0]  cal_cnt_q, cal_cnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [MEM_AW-1:0] base_q, base_d;
   logic              init_calib_q, init_calib_d;
   logic              rd_valid_q, rd_valid_d;
   logic              overrun_q, overrun_d;
   logic [31:0]       rd_data_q;

   logic              wr_en_c;
   logic [MEM_AW-1:0] wr_addr_c;
   logic              rd_en_c;
   logic [MEM_AW-1:0] rd_addr_c;
   logic [MEM_AW-1:0] beat_addr_c;
   logic              addr_unused_c;

   logic [31:0]       mem [DEPTH];

   // Upper address bits are outside the modelled memory and are ignored.
   assign addr_unused_c = ^addr[ADDR_WIDTH-1:MEM_AW];

   // Beat address wraps naturally at the top of memory.
   assign beat_addr_c = MEM_AW'(base_q + MEM_AW'(cnt_q));

   // Next-state, counters and RAM strobes.
   always_comb begin
      state_d      = state_q;
      cal_cnt_d    = cal_cnt_q;
      cnt_d        = cnt_q;
      base_d       = base_q;
      init_calib_d = init_calib_q;
      rd_valid_d   = 1'b0;
      overrun_d    = overrun_q;
      wr_en_c      = 1'b0;
      wr_addr_c    = beat_addr_c;
      rd_en_c      = 1'b0;
      rd_addr_c    = beat_addr_c;

      if (cmd_en && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         CALIB: begin
            cal_cnt_d = CAL_W'(cal_cnt_q + 1'b1);
            if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
               init_calib_d = 1'b1;
               state_d      = IDLE;
            end
         end
         IDLE: begin
            if (cmd_en) begin
               base_d = addr[MEM_AW-1:0];
               if (cmd) begin
                  // Beat 0 is written in the command cycle itself.
                  wr_en_c   = 1'b1;
                  wr_addr_c = addr[MEM_AW-1:0];
                  cnt_d     = CNT_W'(1);
                  state_d   = WRITE;
               end else begin
                  cnt_d   = '0;
                  state_d = RD_WAIT;
               end
            end
         end
         WRITE: begin
            wr_en_c = 1'b1;
            cnt_d   = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(BURST_WORDS - 1)) begin
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
            // RAM is registered, so beat 0 is fetched one cycle before it is due.
            if (cnt_q == CNT_W'(RD_LATENCY - 2)) begin
               rd_en_c    = 1'b1;
               rd_addr_c  = base_q;
               rd_valid_d = 1'b1;
               cnt_d      = CNT_W'(1);
               state_d    = RD_DATA;
            end
         end
         RD_DATA: begin
            if (cnt_q == CNT_W'(BURST_WORDS)) begin
               state_d = IDLE;
            end else begin
               rd_en_c    = 1'b1;
               rd_valid_d = 1'b1;
               cnt_d      = CNT_W'(cnt_q + 1'b1);
            end
         end
         default: begin
            state_d = CALIB;
         end
      endcase

      // Reset aborts any beat in flight.
      if (reset) begin
         wr_en_c = 1'b0;
         rd_en_c = 1'b0;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= CALIB;
         cal_cnt_q    <= '0;
         cnt_q        <= '0;
         base_q       <= '0;
         init_calib_q <= 1'b0;
         rd_valid_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cal_cnt_q    <= cal_cnt_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         init_calib_q <= init_calib_d;
         rd_valid_q   <= rd_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   // Byte-masked RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         for (int i = 0; i < 4; i++) begin
            if (!data_mask[i]) begin
               mem[wr_addr_c][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // Registered RAM read port; holds the last beat when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (rd_en_c) begin
         rd_data_q <= mem[rd_addr_c];
      end
   end

   assign init_calib    = init_calib_q;
   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_valid_q;
   assign cmd_overrun   = overrun_q;

endmodule

// File: tb/tb_psram_channel_responder.sv
// Bench for psram_channel_responder: directed vector table, hand sequences and random traffic
// compared cycle by cycle against a cycle-count based model of the channel.
module tb_psram_channel_responder;

   localparam int unsigned MEM_AW     = 12;
   localparam int unsigned ADDR_WIDTH = 21;
   localparam int          B          = 4;
   localparam int          L          = 6;
   localparam int          CAL        = 64;
   localparam int          DEPTH      = 1 << MEM_AW;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  init_calib;
   logic                  cmd;
   logic                  cmd_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           wr_data;
   logic [3:0]            data_mask;
   logic [31:0]           rd_data;
   logic                  rd_data_valid;
   logic                  cmd_overrun;

   psram_channel_responder #(
      .MEM_AW(MEM_AW), .ADDR_WIDTH(ADDR_WIDTH), .BURST_WORDS(B),
      .RD_LATENCY(L), .CALIB_CYCLES(CAL)
   ) dut (
      .clk(clk), .reset(reset), .init_calib(init_calib), .cmd(cmd), .cmd_en(cmd_en),
      .addr(addr), .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
      .rd_data_valid(rd_data_valid), .cmd_overrun(cmd_overrun)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   // Reference model state: memory image, scheduled read beats keyed by cycle, timing marks.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] exp_rd [int];
   int          cal_done;
   int          next_ok;
   bit          m_ovr;
   bit          m_wr_act;
   int          m_wr_t;
   int          m_wr_base;
   int          cyc;
   int          checks;
   int          errors;
   logic [31:0] cap_q [$];

   typedef struct {
      bit               c;
      int               a;
      logic [3:0][31:0] w;   // write data, or expected read beats
      logic [15:0]      m;   // mask nibble per write beat
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mkv(bit c, int a, logic [31:0] w0, logic [31:0] w1,
                                logic [31:0] w2, logic [31:0] w3, logic [15:0] m);
      vec_t v;
      v.c = c; v.a = a; v.m = m;
      v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic void wmem(int a, logic [31:0] d, logic [3:0] m);
      for (int i = 0; i < 4; i++) begin
         if (!m[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
      end
   endfunction

   // Advance the model by the inputs of the current cycle.
   task automatic model_apply();
      int a;
      int dq [$];
      a = int'(addr[MEM_AW-1:0]);
      if (reset) begin
         cal_done = cyc + 1 + CAL;
         next_ok  = cal_done;
         m_ovr    = 1'b0;
         m_wr_act = 1'b0;
         foreach (exp_rd[k]) if (k > cyc) dq.push_back(k);
         foreach (dq[i]) exp_rd.delete(dq[i]);
      end else begin
         if (m_wr_act && cyc > m_wr_t && cyc < m_wr_t + B)
            wmem((m_wr_base + cyc - m_wr_t) % DEPTH, wr_data, data_mask);
         if (cmd_en) begin
            if (cyc >= next_ok) begin
               if (cmd) begin
                  wmem(a, wr_data, data_mask);
                  m_wr_act  = 1'b1;
                  m_wr_t    = cyc;
                  m_wr_base = a;
                  next_ok   = cyc + B;
               end else begin
                  for (int k = 0; k < B; k++) exp_rd[cyc + L + k] = m_mem[(a + k) % DEPTH];
                  next_ok = cyc + L + B;
               end
            end else begin
               m_ovr = 1'b1;
            end
         end
      end
   endtask

   task automatic observe();
      bit ev;
      ev = exp_rd.exists(cyc);
      chk("init_calib", 32'(init_calib), 32'(cyc >= cal_done));
      chk("cmd_overrun", 32'(cmd_overrun), 32'(m_ovr));
      chk("rd_data_valid", 32'(rd_data_valid), 32'(ev));
      if (ev && rd_data_valid) chk("rd_data", rd_data, exp_rd[cyc]);
      if (rd_data_valid) cap_q.push_back(rd_data);
      if (ev) exp_rd.delete(cyc);
   endtask

   task automatic tick();
      model_apply();
      @(posedge clk);
      #1;
      cyc++;
      observe();
   endtask

   task automatic set_idle();
      reset     = 1'b0;
      cmd_en    = 1'b0;
      cmd       = 1'($urandom);
      addr      = ADDR_WIDTH'($urandom);
      wr_data   = $urandom;
      data_mask = 4'($urandom);
   endtask

   // Drive one command and its beats, returning at the earliest next accept cycle.
   task automatic issue(input vec_t v);
      reset     = 1'b0;
      cmd_en    = 1'b1;
      cmd       = v.c;
      addr      = ADDR_WIDTH'(v.a);
      wr_data   = v.c ? v.w[0] : $urandom;
      data_mask = v.c ? v.m[3:0] : 4'($urandom);
      tick();
      set_idle();
      for (int k = 1; k < B; k++) begin
         if (v.c) begin
            wr_data   = v.w[k];
            data_mask = v.m[4*k +: 4];
         end
         tick();
      end
      set_idle();
      if (!v.c) repeat (L) tick();
   endtask

   task automatic wait_calib();
      for (int i = 0; i < CAL + 10 && !init_calib; i++) tick();
      chk("calib_wait", 32'(init_calib), 32'd1);
   endtask

   int t0;

   initial begin
      checks = 0; errors = 0;
      cal_done = 0; next_ok = 0; m_ovr = 0; m_wr_act = 0; m_wr_t = 0; m_wr_base = 0;
      cmd_en = 0; cmd = 0; addr = '0; wr_data = '0; data_mask = '0;
      reset = 1'b1;
      cyc = -3;

      // Calibration window and a dropped command during it.
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_valid", 32'(rd_data_valid), 32'd0);
      chk("rst_overrun", 32'(cmd_overrun), 32'd0);
      while (cyc < 10) tick();
      cmd_en = 1'b1; cmd = 1'b1; addr = ADDR_WIDTH'(32'h10); wr_data = 32'h5A5A5A5A; data_mask = 4'h0;
      tick();
      set_idle();
      chk("calib_overrun", 32'(cmd_overrun), 32'd1);
      while (cyc < 63) tick();
      chk("calib_63", 32'(init_calib), 32'd0);
      tick();
      chk("calib_64", 32'(init_calib), 32'd1);

      // Directed vectors: writes set up memory, reads carry their expected beats.
      tbl.push_back(mkv(1, 'h010, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 16'h0000));
      tbl.push_back(mkv(0, 'h010, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 16'h0000));
      tbl.push_back(mkv(1, 'h020, 32'hAABBCCDD, 32'h00000021, 32'h00000022, 32'h00000023, 16'h0000));
      tbl.push_back(mkv(1, 'h020, 32'h11223344, 32'h99999999, 32'h99999999, 32'h99999999, 16'hFFF5));
      tbl.push_back(mkv(0, 'h020, 32'h11BB33DD, 32'h00000021, 32'h00000022, 32'h00000023, 16'h0000));
      tbl.push_back(mkv(1, 'h000, 32'hE0E0E0E0, 32'hE1E1E1E1, 32'hE2E2E2E2, 32'hE3E3E3E3, 16'h0000));
      tbl.push_back(mkv(1, 'hFFE, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 16'h0000));
      tbl.push_back(mkv(0, 'h000, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hE2E2E2E2, 32'hE3E3E3E3, 16'h0000));
      tbl.push_back(mkv(0, 'hFFE, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 16'h0000));
      tbl.push_back(mkv(0, 'h1F0010, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 16'h0000));
      for (int i = 0; i < tbl.size(); i++) begin
         cap_q.delete();
         issue(tbl[i]);
         if (!tbl[i].c) begin
            chk("vec_beats", 32'(cap_q.size()), 32'(B));
            for (int k = 0; k < B && k < cap_q.size(); k++) chk("vec_data", cap_q[k], tbl[i].w[k]);
         end
      end

      // Fill all of memory so random reads have known contents.
      for (int a = 0; a < DEPTH; a += B)
         issue(mkv(1, a, $urandom, $urandom, $urandom, $urandom, 16'h0000));

      // Overlapping command during a read is dropped; the next on-time command is taken.
      reset = 1'b1; tick(); set_idle();
      wait_calib();
      cap_q.delete();
      t0 = cyc;
      cmd_en = 1'b1; cmd = 1'b0; addr = ADDR_WIDTH'(32'h10);
      tick(); set_idle();
      while (cyc < t0 + 3) tick();
      cmd_en = 1'b1; cmd = 1'b0; addr = ADDR_WIDTH'(32'h20);
      tick(); set_idle();
      chk("ovr_set", 32'(cmd_overrun), 32'd1);
      while (cyc < t0 + 10) tick();
      chk("ovr_beats", 32'(cap_q.size()), 32'(B));
      cmd_en = 1'b1; cmd = 1'b0; addr = ADDR_WIDTH'(32'h30);
      tick(); set_idle();
      while (cyc < t0 + 20) tick();
      chk("next_beats", 32'(cap_q.size()), 32'(2 * B));
      if (cap_q.size() == 2 * B) chk("next_data", cap_q[B], m_mem['h30]);

      // Reset mid-read with a simultaneous cmd_en, then a write attempt during recalibration.
      cap_q.delete();
      t0 = cyc;
      cmd_en = 1'b1; cmd = 1'b0; addr = ADDR_WIDTH'(32'h40);
      tick(); set_idle();
      while (cyc < t0 + 7) tick();
      reset = 1'b1; cmd_en = 1'b1; cmd = 1'b1;
      tick(); set_idle();
      chk("rst_abort_valid", 32'(rd_data_valid), 32'd0);
      chk("rst_abort_calib", 32'(init_calib), 32'd0);
      chk("rst_abort_ovr", 32'(cmd_overrun), 32'd0);
      chk("rst_abort_beats", 32'(cap_q.size()), 32'd2);
      while (cyc < t0 + 20) tick();
      cmd_en = 1'b1; cmd = 1'b1; addr = ADDR_WIDTH'(32'h40); wr_data = 32'hDEADBEEF; data_mask = 4'h0;
      repeat (B) tick();
      set_idle();
      wait_calib();
      cap_q.delete();
      issue(mkv(0, 'h40, 0, 0, 0, 0, 16'h0000));
      chk("reread_beats", 32'(cap_q.size()), 32'(B));
      if (cap_q.size() == B) chk("reread_data", cap_q[0], m_mem['h40]);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 399) == 0);
         cmd_en    = ($urandom_range(0, 99) < 30);
         cmd       = 1'($urandom);
         addr      = ADDR_WIDTH'($urandom);
         wr_data   = $urandom;
         data_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         tick();
      end
      set_idle();
      repeat (L + B + 2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
